port_variant_pipe: RTL



---
 rtl/vtuber_pkg.sv | 22 ++
 rtl/pipe_chain.sv | 77 +++++++
 rtl/port_variant_pipe.sv | 67 ++++++
 3 files changed

// File: rtl/vtuber_pkg.sv
// Shared types for the vtuber port/handshake regression target:
// the packed struct payload and the transfer-counter width.
package vtuber_pkg;

    localparam int CNT_W = 16;

    typedef struct packed {
        logic [19:0] a20;
        logic [19:0] b20;
    } Struct;

    localparam int STRUCT_W = $bits(Struct);

    // Counter advance that wraps silently at 2**CNT_W.
    function automatic logic [CNT_W-1:0] cnt_step(
        input logic [CNT_W-1:0] cnt,
        input logic             hit
    );
        return hit ? cnt + 1'b1 : cnt;
    endfunction

endpackage

// File: rtl/pipe_chain.sv
// One valid/ready register chain of DEPTH stages with a combinational
// ready path and a wrapping count of output handshakes.
module pipe_chain
    import vtuber_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [CNT_W-1:0] cnt
);

    logic [DEPTH-1:0]        v_q;
    logic [DEPTH-1:0]        v_d;
    logic [DEPTH-1:0][W-1:0] d_q;
    logic [DEPTH-1:0][W-1:0] d_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    logic [DEPTH:0]          rdy;

    // A stage can take new data when it is empty or its successor moves,
    // which lets bubbles collapse while the output is stalled.
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            rdy[k] = !v_q[k] || rdy[k+1];
        end
    end

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (rdy[0]) begin
            v_d[0] = in_valid;
            d_d[0] = in_data;
        end
        for (int k = 1; k < DEPTH; k++) begin
            if (rdy[k]) begin
                v_d[k] = v_q[k-1];
                d_d[k] = d_q[k-1];
            end
        end
    end

    always_comb begin
        cnt_d = cnt_step(cnt_q, out_valid && out_ready);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q   <= '0;
            cnt_q <= '0;
        end else begin
            v_q   <= v_d;
            cnt_q <= cnt_d;
        end
    end

    // Payload registers carry no reset; they are only observed behind valid.
    always_ff @(posedge clk) begin
        d_q <= d_d;
    end

    assign in_ready  = rdy[0] || !rst_n;
    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];
    assign cnt       = cnt_q;

endmodule

// File: rtl/port_variant_pipe.sv
// NCH plain data channels plus one struct channel, each an independent
// DEPTH-stage valid/ready pipeline with its own transfer counter.
module port_variant_pipe
    import vtuber_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NCH   = 2,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NCH-1:0]           i_valid,
    output logic [NCH-1:0]           i_ready,
    input  logic [NCH*WIDTH-1:0]     i_data,
    output logic [NCH-1:0]           o_valid,
    input  logic [NCH-1:0]           o_ready,
    output logic [NCH*WIDTH-1:0]     o_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  Struct                    s_in,
    output logic                     s_out_valid,
    input  logic                     s_out_ready,
    output Struct                    s_out,
    output logic [(NCH+1)*CNT_W-1:0] xfer_cnt
);

    logic [STRUCT_W-1:0] s_in_raw;
    logic [STRUCT_W-1:0] s_out_raw;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        pipe_chain #(
            .W     (WIDTH),
            .DEPTH (DEPTH)
        ) u_chain (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (i_valid[c]),
            .in_ready  (i_ready[c]),
            .in_data   (i_data[c*WIDTH +: WIDTH]),
            .out_valid (o_valid[c]),
            .out_ready (o_ready[c]),
            .out_data  (o_data[c*WIDTH +: WIDTH]),
            .cnt       (xfer_cnt[c*CNT_W +: CNT_W])
        );
    end

    // The struct channel travels as a flat vector and occupies counter slot NCH.
    assign s_in_raw = s_in;

    pipe_chain #(
        .W     (STRUCT_W),
        .DEPTH (DEPTH)
    ) u_struct_chain (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s_valid),
        .in_ready  (s_ready),
        .in_data   (s_in_raw),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_data  (s_out_raw),
        .cnt       (xfer_cnt[NCH*CNT_W +: CNT_W])
    );

    assign s_out = s_out_raw;

endmodule
